sobel_stream_engine: RTL and testbench

- Parametrised successor to the fixed 320x240 gray-to-Sobel stage.
- Streams a gray image out of the gray BRAM at 1 pixel/clk and forms a 3x3 window from two internal line buffers.
- Writes the Sobel magnitude of every interior row into the Sobel BRAM.
- Image size, pixel width and magnitude scaling are parameters; started and monitored by the AXI control side.

---
 rtl/sobel_pkg.sv | 25 ++
 rtl/sobel_line_buffer.sv | 29 ++
 rtl/sobel_stream_engine.sv | 199 +++++++++++++++++++
 tb/tb_sobel_stream_engine.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// sobel_pkg: shared types, constants and helpers for sobel_stream_engine.
//   state_t   - engine FSM states
//   K_SIDE/K_MID - Sobel kernel weights (outer / centre tap)
//   PIPE_LAT  - cycles from a gray read request to its Sobel write
//   abs_s()   - absolute value of a 32-bit signed value
//   sat_u()   - clamp an unsigned value to pix_w bits
package sobel_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN, ST_DONE} state_t;

  localparam int K_SIDE   = 1;
  localparam int K_MID    = 2;
  localparam int PIPE_LAT = 4;

  function automatic logic [31:0] abs_s(input logic signed [31:0] x);
    return x[31] ? 32'(-x) : 32'(x);
  endfunction

  function automatic logic [31:0] sat_u(input logic [31:0] x, input int pix_w);
    logic [31:0] mx;
    mx = (32'd1 << pix_w) - 32'd1;
    return (x > mx) ? mx : x;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer: one image row of delay, a simple dual-port RAM with
// one registered read port and one write port.
//   clk              - clock
//   rd_en/rd_addr    - read request; rd_data valid the next cycle
//   wr_en/wr_addr/wr_data - write port
// Contents are never cleared; the engine only consumes locations it has
// written earlier in the same frame.
module sobel_line_buffer #(
  parameter int DEPTH = 320,
  parameter int WIDTH = 8,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sobel_stream_engine.sv
// sobel_stream_engine: streams a gray frame out of BRAM at one pixel per
// clock, builds a 3x3 window from two line buffers and writes the Sobel
// magnitude of every interior row into the Sobel BRAM.
//   i_CLK, i_RST      - clock, synchronous active-high reset
//   i_START           - start pulse (ignored unless idle)
//   i_THRESH          - binarisation threshold (only with SOBEL_THRESH_EN)
//   o_BUSY, o_DONE    - run status, one-cycle done pulse after last write
//   o_GRAY_RD*        - gray BRAM read port (1-cycle read latency)
//   o_SOBEL_WR*       - Sobel BRAM write port
// Build option: define SOBEL_THRESH_EN to write (mag >= i_THRESH) ? max : 0.
// Pipeline: request -> BRAM/line-buffer data -> window -> Gx/Gy -> write.
module sobel_stream_engine
  import sobel_pkg::*;
#(
  parameter int IMG_W     = 320,
  parameter int IMG_H     = 240,
  parameter int PIX_W     = 8,
  parameter int ADDR_W    = 17,
  parameter int MAG_SHIFT = 0
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic              i_START,
`ifdef SOBEL_THRESH_EN
  input  logic [PIX_W-1:0]  i_THRESH,
`endif
  output logic              o_BUSY,
  output logic              o_DONE,
  output logic [ADDR_W-1:0] o_GRAY_RDADDR,
  output logic              o_GRAY_RDEN,
  input  logic [PIX_W-1:0]  i_GRAY_RDDATA,
  output logic [ADDR_W-1:0] o_SOBEL_WRADDR,
  output logic [PIX_W-1:0]  o_SOBEL_WRDATA,
  output logic              o_SOBEL_WREN
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int GW = PIX_W + 4;
  localparam logic [ADDR_W-1:0] LAST_RD = ADDR_W'(IMG_W*IMG_H - 1);
  localparam logic [ADDR_W-1:0] LAST_WR = ADDR_W'(IMG_W*(IMG_H-2) - 1);

  state_t          state;
  logic [CW-1:0]   col_i;
  logic [RW-1:0]   row_i;
`ifdef SOBEL_THRESH_EN
  logic [PIX_W-1:0] thresh_q;
`endif

  // Control FSM and read address generator
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state         <= ST_IDLE;
      o_BUSY        <= 1'b0;
      o_DONE        <= 1'b0;
      o_GRAY_RDEN   <= 1'b0;
      o_GRAY_RDADDR <= '0;
      col_i         <= '0;
      row_i         <= '0;
`ifdef SOBEL_THRESH_EN
      thresh_q      <= '0;
`endif
    end else begin
      o_DONE <= 1'b0;
      case (state)
        ST_IDLE: if (i_START) begin
          state         <= ST_READ;
          o_BUSY        <= 1'b1;
          o_GRAY_RDEN   <= 1'b1;
          o_GRAY_RDADDR <= '0;
          col_i         <= '0;
          row_i         <= '0;
`ifdef SOBEL_THRESH_EN
          thresh_q      <= i_THRESH;
`endif
        end
        ST_READ: if (o_GRAY_RDADDR == LAST_RD) begin
          state       <= ST_DRAIN;
          o_GRAY_RDEN <= 1'b0;
        end else begin
          o_GRAY_RDADDR <= o_GRAY_RDADDR + ADDR_W'(1);
          if (col_i == CW'(IMG_W-1)) begin
            col_i <= '0;
            row_i <= row_i + RW'(1);
          end else begin
            col_i <= col_i + CW'(1);
          end
        end
        // Output registers are visible here, so the last write is seen
        // in the same cycle it is presented on the BRAM port.
        ST_DRAIN: if (o_SOBEL_WREN && o_SOBEL_WRADDR == LAST_WR) begin
          state  <= ST_DONE;
          o_DONE <= 1'b1;
          o_BUSY <= 1'b0;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Per-pixel sideband computed at request time
  logic              wr_i, inner_i;
  logic [ADDR_W-1:0] waddr_i;
  assign wr_i    = (row_i >= RW'(2));
  assign inner_i = (col_i >= CW'(2));
  assign waddr_i = o_GRAY_RDADDR - ADDR_W'(2*IMG_W);

  logic [PIPE_LAT-1:1] vld_pipe, wr_pipe, inner_pipe;
  logic [ADDR_W-1:0]   waddr_pipe [PIPE_LAT-1:1];
  logic [CW-1:0]       col1;

  always_ff @(posedge i_CLK) begin
    if (i_RST) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[PIPE_LAT-2:1], o_GRAY_RDEN};
  end

  always_ff @(posedge i_CLK) begin
    wr_pipe       <= {wr_pipe[PIPE_LAT-2:1], wr_i};
    inner_pipe    <= {inner_pipe[PIPE_LAT-2:1], inner_i};
    waddr_pipe[1] <= waddr_i;
    for (int i = 2; i < PIPE_LAT; i++) waddr_pipe[i] <= waddr_pipe[i-1];
    col1 <= col_i;
  end

  // Line buffers are read alongside the gray BRAM so row r-1 / r-2 land in
  // the same cycle as row r. lb2 is refilled from lb1's output, so it
  // trails by exactly one more row.
  logic [PIX_W-1:0] up1, up2;

  sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
    .clk(i_CLK), .rd_en(o_GRAY_RDEN), .rd_addr(col_i), .rd_data(up1),
    .wr_en(vld_pipe[1]), .wr_addr(col1), .wr_data(i_GRAY_RDDATA)
  );

  sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb2 (
    .clk(i_CLK), .rd_en(o_GRAY_RDEN), .rd_addr(col_i), .rd_data(up2),
    .wr_en(vld_pipe[1]), .wr_addr(col1), .wr_data(up1)
  );

  // Window: win[row][col], row 0 = r-2 (top), col 2 = c (right)
  logic [PIX_W-1:0] win [3][3];

  always_ff @(posedge i_CLK) begin
    if (vld_pipe[1]) begin
      for (int i = 0; i < 3; i++) begin
        win[i][0] <= win[i][1];
        win[i][1] <= win[i][2];
      end
      win[0][2] <= up2;
      win[1][2] <= up1;
      win[2][2] <= i_GRAY_RDDATA;
    end
  end

  int gx_c, gy_c;
  always_comb begin
    gx_c = K_SIDE*(int'(win[0][2]) - int'(win[0][0]))
         + K_MID *(int'(win[1][2]) - int'(win[1][0]))
         + K_SIDE*(int'(win[2][2]) - int'(win[2][0]));
    gy_c = K_SIDE*(int'(win[2][0]) - int'(win[0][0]))
         + K_MID *(int'(win[2][1]) - int'(win[0][1]))
         + K_SIDE*(int'(win[2][2]) - int'(win[0][2]));
  end

  logic signed [GW-1:0] gx_q, gy_q;
  always_ff @(posedge i_CLK) begin
    gx_q <= GW'(gx_c);
    gy_q <= GW'(gy_c);
  end

  logic [31:0]      sum_c;
  logic [PIX_W-1:0] mag_c, wdat_c;
  always_comb begin
    sum_c = abs_s(32'(gx_q)) + abs_s(32'(gy_q));
    mag_c = PIX_W'(sat_u(sum_c >> MAG_SHIFT, PIX_W));
`ifdef SOBEL_THRESH_EN
    wdat_c = (mag_c >= thresh_q) ? '1 : '0;
`else
    wdat_c = mag_c;
`endif
    if (!inner_pipe[PIPE_LAT-1]) wdat_c = '0;
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      o_SOBEL_WREN   <= 1'b0;
      o_SOBEL_WRADDR <= '0;
      o_SOBEL_WRDATA <= '0;
    end else begin
      o_SOBEL_WREN <= vld_pipe[PIPE_LAT-1] & wr_pipe[PIPE_LAT-1];
      if (vld_pipe[PIPE_LAT-1]) begin
        o_SOBEL_WRADDR <= waddr_pipe[PIPE_LAT-1];
        o_SOBEL_WRDATA <= wdat_c;
      end
    end
  end

endmodule

// File: tb/tb_sobel_stream_engine.sv
// tb_sobel_stream_engine: four engine instances (5x4, 5x4 with shift 3,
// 16x12, 320x240) share one image store. Each run is compared cycle by
// cycle against a frame-level Sobel model; literal row patterns pin the
// model. Build option SOBEL_THRESH_EN is honoured.
module tb_sobel_stream_engine;

  localparam int NI = 4;
  localparam int WS [NI] = '{5, 5, 16, 320};
  localparam int HS [NI] = '{4, 4, 12, 240};
  localparam int SS [NI] = '{0, 3, 0, 0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start [NI];
  logic busy [NI], done [NI], rden [NI], wren [NI];
  logic [16:0] rdaddr [NI], wraddr [NI];
  logic [7:0]  wrdata [NI];
`ifdef SOBEL_THRESH_EN
  logic [7:0]  thr [NI];
`endif

  logic [7:0] img [76800];
  logic [7:0] cap [76800];

  int checks = 0, errors = 0;
  int cycle = 0, c0 = 0, act = 0;
  bit mon = 1'b0;
  int nwr, last_wa, done_sc;
  int m_sc, m_n, m_w, m_k;
  bit m_wr;

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cycle++; end

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [7:0] rd;
    always @(posedge clk) if (rden[g]) rd <= img[rdaddr[g]];
    sobel_stream_engine #(.IMG_W(WS[g]), .IMG_H(HS[g]), .PIX_W(8),
                          .ADDR_W(17), .MAG_SHIFT(SS[g])) u_dut (
      .i_CLK(clk), .i_RST(rst), .i_START(start[g]),
`ifdef SOBEL_THRESH_EN
      .i_THRESH(thr[g]),
`endif
      .o_BUSY(busy[g]), .o_DONE(done[g]),
      .o_GRAY_RDADDR(rdaddr[g]), .o_GRAY_RDEN(rden[g]), .i_GRAY_RDDATA(rd),
      .o_SOBEL_WRADDR(wraddr[g]), .o_SOBEL_WRDATA(wrdata[g]),
      .o_SOBEL_WREN(wren[g])
    );
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", nm, got, exp, cycle);
    end
  endtask

  function automatic int px(input int g, input int r, input int c);
    return int'(img[r*WS[g] + c]);
  endfunction

  // Sobel output for write index j of instance g, straight from the image
  function automatic int ref_out(input int g, input int j);
    int w, rr, cc, gx, gy, wt, m;
    w = WS[g]; rr = j / w; cc = j % w;
    if (cc < 2) return 0;
    gx = 0; gy = 0;
    for (int i = 0; i < 3; i++) begin
      wt = (i == 1) ? 2 : 1;
      gx += wt * (px(g, rr+i, cc) - px(g, rr+i, cc-2));
      gy += wt * (px(g, rr+2, cc-2+i) - px(g, rr, cc-2+i));
    end
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    m = (gx + gy) >>> SS[g];
    if (m > 255) m = 255;
`ifdef SOBEL_THRESH_EN
    m = (m >= int'(thr[g])) ? 255 : 0;
`endif
    return m;
  endfunction

  task automatic fill(input int g, input int mode);
    for (int r = 0; r < HS[g]; r++)
      for (int c = 0; c < WS[g]; c++) begin
        case (mode)
          0: img[r*WS[g]+c] = 8'd100;
          1: img[r*WS[g]+c] = (c >= 3) ? 8'd255 : 8'd0;
          2: img[r*WS[g]+c] = (r >= 2) ? 8'd200 : 8'd0;
          default: begin
            img[r*WS[g]+c] = 8'((r*3 + c*2 + int'($urandom_range(0, 30))) & 255);
            if ($urandom_range(0, 15) == 0) img[r*WS[g]+c] = 8'($urandom);
          end
        endcase
      end
  endtask

  // Cycle-by-cycle compare; sc = 0 is the cycle i_START was high
  initial forever begin
    @(negedge clk);
    if (mon) begin
      m_w  = WS[act];
      m_n  = m_w * HS[act];
      m_sc = cycle - c0 + 1;
      chk("rden", int'(rden[act]), int'(m_sc >= 1 && m_sc <= m_n));
      if (m_sc >= 1 && m_sc <= m_n) chk("rdaddr", int'(rdaddr[act]), m_sc - 1);
      m_k  = m_sc - 5;
      m_wr = (m_k >= 2*m_w) && (m_k <= m_n - 1);
      chk("wren", int'(wren[act]), int'(m_wr));
      if (m_wr) begin
        chk("wraddr", int'(wraddr[act]), m_k - 2*m_w);
        chk("wrdata", int'(wrdata[act]), ref_out(act, m_k - 2*m_w));
      end
      if (wren[act]) begin
        nwr++;
        last_wa = int'(wraddr[act]);
        if (wraddr[act] < 17'd76800) cap[wraddr[act]] = wrdata[act];
      end
      chk("done", int'(done[act]), int'(m_sc == m_n + 5));
      if (done[act]) done_sc = m_sc;
      if (m_sc <= m_n + 4)      chk("busy", int'(busy[act]), 1);
      else if (m_sc >= m_n + 6) chk("busy", int'(busy[act]), 0);
    end
  end

  // Pokes i_START mid-run and during the done cycle; both must be ignored
  task automatic run(input int g);
    int n;
    n = WS[g] * HS[g];
    nwr = 0; last_wa = -1; done_sc = -1;
    @(negedge clk); start[g] = 1'b1; act = g;
    @(posedge clk); #1 start[g] = 1'b0; c0 = cycle; mon = 1'b1;
    for (int s = 1; s <= n + 8; s++) begin
      @(negedge clk);
      start[g] = (s == n/2) || (s == n + 5);
    end
    start[g] = 1'b0;
    mon = 1'b0;
  endtask

  task automatic reset_mid();
    fill(2, 3);
    @(negedge clk); start[2] = 1'b1; act = 2;
    @(posedge clk); #1 start[2] = 1'b0; c0 = cycle; mon = 1'b1;
    for (int s = 1; s <= 5 + 2*WS[2] + 50; s++) @(negedge clk);
    chk("wr50_en", int'(wren[2]), 1);
    chk("wr50_addr", int'(wraddr[2]), 50);
    mon = 1'b0; rst = 1'b1; start[2] = 1'b1; start[0] = 1'b1;
    @(posedge clk); #1 rst = 1'b0; start[2] = 1'b0; start[0] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("rst_wren", int'(wren[2]), 0);
      chk("rst_busy", int'(busy[2]), 0);
      chk("rst_done", int'(done[2]), 0);
      chk("rst_rden", int'(rden[2]), 0);
      chk("rst_start_busy", int'(busy[0]), 0);
    end
  endtask

  int ev [5];
  int hv [5];
  int sv [5];

  initial begin
    for (int i = 0; i < NI; i++) start[i] = 1'b0;
`ifdef SOBEL_THRESH_EN
    thr[0] = 8'd128; thr[1] = 8'd255; thr[2] = 8'd128; thr[3] = 8'd100;
    sv = '{0, 0, 0, 0, 0};
`else
    sv = '{0, 0, 0, 127, 127};
`endif
    ev = '{0, 0, 0, 255, 255};
    hv = '{0, 0, 255, 255, 255};

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      chk("reset_busy", int'(busy[g]), 0);
      chk("reset_done", int'(done[g]), 0);
      chk("reset_rden", int'(rden[g]), 0);
      chk("reset_wren", int'(wren[g]), 0);
      chk("reset_rdaddr", int'(rdaddr[g]), 0);
      chk("reset_wraddr", int'(wraddr[g]), 0);
      chk("reset_wrdata", int'(wrdata[g]), 0);
    end
    rst = 1'b0;

    // flat image: no gradient anywhere
    fill(0, 0); run(0);
    chk("flat_nwr", nwr, 10);
    chk("flat_done_cyc", done_sc, 25);
    for (int i = 0; i < 10; i++) chk("flat_data", int'(cap[i]), 0);

    // vertical edge
    fill(0, 1);
    chk("model_vedge", ref_out(0, 3), 255);
    run(0);
    for (int i = 0; i < 10; i++) chk("vedge_data", int'(cap[i]), ev[i % 5]);

    // horizontal edge
    fill(0, 2); run(0);
    for (int i = 0; i < 10; i++) chk("hedge_data", int'(cap[i]), hv[i % 5]);

    // vertical edge with MAG_SHIFT=3
    fill(1, 1); run(1);
    for (int i = 0; i < 10; i++) chk("vedge_shift_data", int'(cap[i]), sv[i % 5]);

    fill(2, 3); run(2);
    chk("rand16_nwr", nwr, 160);

    reset_mid();
    fill(2, 3); run(2);
    chk("after_rst_nwr", nwr, 160);
    chk("after_rst_done_cyc", done_sc, 197);

    fill(3, 3); run(3);
    chk("full_nwr", nwr, 76160);
    chk("full_last_addr", last_wa, 76159);
    chk("full_done_cyc", done_sc, 76805);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cycle);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
